bin27_to_dec8: RTL and testbench

BIN27_TO_DEC8 -- requirements
Module: bin27_to_dec8

---
 rtl/bin27_to_dec8_pkg.sv | 11 +
 rtl/bcd_dig_adj.sv | 7 +
 rtl/bin27_to_dec8.sv | 55 +++++
 tb/tb_bin27_to_dec8.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/bin27_to_dec8_pkg.sv
// bin27_to_dec8_pkg: shared widths, limits and FSM states for the 27-bit binary to 8-digit BCD converter
package bin27_to_dec8_pkg;
  localparam int BIN_W = 27;
  localparam int NDIG = 8;
  localparam int DEC_W = 32;
  localparam int STEPS = 27;
  localparam logic [BIN_W-1:0] DEC_MAX = 27'd99_999_999;
  localparam logic [DEC_W-1:0] DEC_SAT = 32'h9999_9999;
  localparam logic [4:0] CNT_LAST = 5'(STEPS - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
endpackage

// File: rtl/bcd_dig_adj.sv
// bcd_dig_adj: double-dabble digit pre-shift adjust, add 3 to any digit of 5 or more
module bcd_dig_adj (
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);
  assign o_dig = i_dig >= 4'd5 ? i_dig + 4'd3 : i_dig;
endmodule

// File: rtl/bin27_to_dec8.sv
// bin27_to_dec8: sequential shift-add-3 conversion of a 27-bit value to 8 BCD digits, saturating above 99,999,999
module bin27_to_dec8
  import bin27_to_dec8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] BIN,
  input  logic             st,
  output logic [DEC_W-1:0] DEC,
  output logic             ok,
  output logic             busy,
  output logic             ovf
);
  state_t           r_state;
  logic [BIN_W-1:0] r_sh;
  logic [DEC_W-1:0] r_acc;
  logic [4:0]       r_cnt;
  logic             r_ovf_p;
  logic [DEC_W-1:0] w_adj;
  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_dig_adj u_adj (.i_dig(r_acc[4*g +: 4]), .o_dig(w_adj[4*g +: 4]));
  end
  assign busy = r_state != S_IDLE;
  // st has priority in every state so a new request always aborts the running one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sh    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf_p <= 1'b0;
      DEC     <= '0;
      ok      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ok <= 1'b0;
      if (st) begin
        r_state <= S_SHIFT;
        r_sh    <= BIN;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_ovf_p <= BIN > DEC_MAX;
      end else if (r_state == S_SHIFT) begin
        {r_acc, r_sh} <= {w_adj[DEC_W-2:0], r_sh, 1'b0};
        r_cnt         <= r_cnt + 5'd1;
        if (r_cnt == CNT_LAST) r_state <= S_DONE;
      end else if (r_state == S_DONE) begin
        DEC     <= r_ovf_p ? DEC_SAT : r_acc;
        ovf     <= r_ovf_p;
        ok      <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_bin27_to_dec8.sv
// tb_bin27_to_dec8: randomized and directed checks of bin27_to_dec8 against a decimal-arithmetic countdown model
module tb_bin27_to_dec8;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [26:0] BIN = '0;
  logic        st = 1'b0;
  logic [31:0] DEC;
  logic        ok, busy, ovf;
  int          n_pass = 0, n_total = 0;
  int          m_cnt = 0;
  logic [26:0] m_bin = '0;
  logic [31:0] m_dec = '0;
  logic        m_ok = 1'b0, m_ovf = 1'b0;

  bin27_to_dec8 dut (.clk(clk), .rst_n(rst_n), .BIN(BIN), .st(st), .DEC(DEC), .ok(ok), .busy(busy), .ovf(ovf));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_dec(input logic [26:0] b);
    int v = int'(b);
    logic [31:0] r = '0;
    if (b > 27'd99_999_999) return 32'h9999_9999;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // one clock: advance the model on the rising edge, compare on the falling edge
  task automatic cycle();
    @(posedge clk);
    m_ok = 1'b0;
    if (st) begin
      m_cnt = 28;
      m_bin = BIN;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_ok  = 1'b1;
        m_dec = ref_dec(m_bin);
        m_ovf = m_bin > 27'd99_999_999;
      end
    end
    @(negedge clk);
    check("ok", 32'(ok), 32'(m_ok));
    check("busy", 32'(busy), 32'(m_cnt != 0));
    check("dec", DEC, m_dec);
    check("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic start(input logic [26:0] b);
    BIN = b;
    st = 1'b1;
    cycle();
    st = 1'b0;
  endtask

  task automatic wait_ok(output int n);
    n = 0;
    while (!ok && n < 40) begin
      BIN = 27'($urandom);
      cycle();
      n++;
    end
    check("ok_seen", 32'(ok), 32'd1);
  endtask

  task automatic run_lit(input string name, input logic [26:0] b, input logic [31:0] exp_dec, input logic exp_ovf);
    int n;
    start(b);
    wait_ok(n);
    check({name, "_lat"}, 32'(n), 32'd28);
    check({name, "_dec"}, DEC, exp_dec);
    check({name, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_dec", DEC, 32'd0);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    m_cnt = 0;
    m_dec = '0;
    m_ok = 1'b0;
    m_ovf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    #2;
    do_reset();
    repeat (3) cycle();
    run_lit("zero", 27'd0, 32'h0000_0000, 1'b0);
    run_lit("mid", 27'd12_345_678, 32'h1234_5678, 1'b0);
    run_lit("max", 27'd99_999_999, 32'h9999_9999, 1'b0);
    run_lit("ovf_lo", 27'd100_000_000, 32'h9999_9999, 1'b1);
    run_lit("ovf_hi", 27'd134_217_727, 32'h9999_9999, 1'b1);
    run_lit("clr_ovf", 27'd1, 32'h0000_0001, 1'b0);
    start(27'd5);
    repeat (9) cycle();
    run_lit("restart", 27'd42, 32'h0000_0042, 1'b0);
    st = 1'b1;
    for (int i = 0; i < 5; i++) begin
      BIN = 27'(300 + i);
      cycle();
    end
    BIN = 27'd777;
    cycle();
    st = 1'b0;
    wait_ok(n);
    check("held_lat", 32'(n), 32'd28);
    check("held_dec", DEC, 32'h0000_0777);
    start(27'd5);
    repeat (14) cycle();
    do_reset();
    repeat (35) cycle();
    check("post_rst_dec", DEC, 32'd0);
    run_lit("after_rst", 27'd7, 32'h0000_0007, 1'b0);
    // each new st lands in the ok cycle of the previous result
    for (int i = 0; i < 1000; i++) begin
      start(27'($urandom_range(0, 99_999_999)));
      wait_ok(n);
      check("rand_lat", 32'(n), 32'd28);
    end
    repeat (3) cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
